fetch_queue_stage: RTL and testbench
====================================

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value after reset.
REQ-004 SHALL have parameter BTFN_EN, default 1, meaning 1 = predict backward conditional branches taken.
REQ-005 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset), asynchronous, active-low.
REQ-006 SHALL have port flush (in, 1, discard queue contents, PC unchanged).
REQ-007 SHALL have ports misprediction (in, 1, redirect request) and correct_pc (in, XLEN, redirect target).
REQ-008 SHALL have ports instruction_i (in, 32, fetched word at current_pc) and instruction_valid (in, 1, instruction_i valid this cycle).
REQ-009 SHALL have port current_pc (out, XLEN, fetch address).
REQ-010 SHALL have ports decode_ready (in, 1) and out_valid (out, 1), the queue-head handshake.
REQ-011 SHALL have head outputs instruction_o (32), imm_o (XLEN), pc_o (XLEN), pc_plus_o (XLEN, pc+4), and branch_prediction_o (1).
REQ-012 SHALL have status outputs count_o ($clog2(DEPTH)+1 bits), full_o (1), empty_o (1), jalr_stall_o (1).

Function
REQ-013 SHALL compute the early immediate from instruction_i[6:0]: JAL -> J-type; BRANCH -> B-type; JALR -> I-type; else 0; sign-extended to XLEN.
REQ-014 SHALL define push = instruction_valid & (~full_o | pop) & ~jalr_stall_o & ~flush & ~misprediction.
REQ-015 SHALL define pop = out_valid & decode_ready.
REQ-016 SHALL, on push, write {instruction_i, imm, current_pc, current_pc+4, pred} at the write pointer.
REQ-017 SHALL set pred = 1 for JAL, and for BRANCH with imm negative when BTFN_EN=1; else pred = 0.
REQ-018 SHALL, on push, set next PC to current_pc+imm when pred=1 and to current_pc+4 otherwise; PC arithmetic wraps modulo 2^XLEN.
REQ-019 SHALL, on push of a JALR, set jalr_stall_o=1 and hold PC; the stall clears only on misprediction.
REQ-020 SHALL hold PC and the queue unchanged when instruction_valid=0 or the queue is full without a pop.
REQ-021 SHALL allow push and pop in the same cycle when full; count is unchanged.
REQ-022 SHALL drive head fields from the read-pointer entry; out_valid = ~empty_o; fields are don't-care when empty.
REQ-023 SHALL give zero-cycle latency from push to out_valid: an entry pushed at edge N is visible after edge N.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; full_o = (count_o==DEPTH); empty_o = (count_o==0).
REQ-025 SHALL, on misprediction, set PC=correct_pc, empty the queue, clear jalr_stall_o, and discard any same-cycle push and pop.
REQ-026 SHALL, on flush without misprediction, empty the queue and discard any push/pop; PC and jalr_stall_o are unchanged.
REQ-027 SHALL give misprediction priority over flush, and flush priority over push/pop.

Reset
REQ-028 SHALL, while reset=0, set current_pc=RESET_PC, count_o=0, pointers=0, jalr_stall_o=0, out_valid=0, full_o=0, empty_o=1.
REQ-029 SHALL drive instruction_o, imm_o, pc_o, pc_plus_o and branch_prediction_o to 0 during reset (storage entries are cleared).
REQ-030 SHALL abandon any in-flight state on mid-operation reset assertion, with no partial entries surviving.

Verification
REQ-031 SHALL have a bench case: reset, then 4 valid ADDI words with decode_ready=0 -> PCs 0,4,8,C queued; full_o=1; PC holds at 0x10.
REQ-032 SHALL have a bench case: JAL imm=+0x20 at PC 0x8 -> entry pred=1, pc_plus_o=0xC; next current_pc=0x28.
REQ-033 SHALL have a bench case: BEQ imm=-8 at 0x40, BTFN_EN=1 -> pred=1, next PC 0x38; with BTFN_EN=0 -> pred=0, next PC 0x44.
REQ-034 SHALL have a bench case: full queue with decode_ready=1 and instruction_valid=1 -> count_o stays 4, head advances every cycle.
REQ-035 SHALL have a bench case: JALR pushed, then misprediction with correct_pc=0x100 -> jalr_stall_o 1->0, queue empty, current_pc=0x100.
REQ-036 SHALL have a bench case: flush and misprediction in the same cycle with 3 entries queued -> count_o=0, current_pc=correct_pc.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Fetch stage with early immediate decode, static branch prediction and an
// in-order instruction queue feeding decode through a valid/ready head.
module fetch_queue_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter bit              BTFN_EN  = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       misprediction,
   input  logic [XLEN-1:0]            correct_pc,
   input  logic [31:0]                instruction_i,
   input  logic                       instruction_valid,
   output logic [XLEN-1:0]            current_pc,
   input  logic                       decode_ready,
   output logic                       out_valid,
   output logic [31:0]                instruction_o,
   output logic [XLEN-1:0]            imm_o,
   output logic [XLEN-1:0]            pc_o,
   output logic [XLEN-1:0]            pc_plus_o,
   output logic                       branch_prediction_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       jalr_stall_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            stall_q, stall_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [31:0]     instr_q [DEPTH];
   logic [XLEN-1:0] imm_q   [DEPTH];
   logic [XLEN-1:0] pc_e_q  [DEPTH];
   logic [XLEN-1:0] pcp_q   [DEPTH];
   logic            pred_q  [DEPTH];

   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_x;
   logic            is_jal, is_branch, is_jalr;
   logic            pred;
   logic [XLEN-1:0] pc_plus4;
   logic            push, pop, pop_eff;

   // Early immediate decode on the incoming word
   always_comb begin
      imm32 = '0;
      case (instruction_i[6:0])
         OpJal:    imm32 = {{12{instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
                            instruction_i[30:21], 1'b0};
         OpBranch: imm32 = {{20{instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                            instruction_i[11:8], 1'b0};
         OpJalr:   imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
         default:  imm32 = '0;
      endcase
   end

   assign imm_x     = XLEN'($signed(imm32));
   assign is_jal    = (instruction_i[6:0] == OpJal);
   assign is_branch = (instruction_i[6:0] == OpBranch);
   assign is_jalr   = (instruction_i[6:0] == OpJalr);
   // Backward-taken, forward-not-taken: a negative branch offset means a loop
   assign pred      = is_jal | (BTFN_EN & is_branch & imm32[31]);
   assign pc_plus4  = pc_q + XLEN'(4);

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assign out_valid    = ~empty_o;
   assign current_pc   = pc_q;
   assign jalr_stall_o = stall_q;

   assign pop     = out_valid & decode_ready;
   assign push    = instruction_valid & (~full_o | pop) & ~stall_q & ~flush & ~misprediction;
   assign pop_eff = pop & ~flush & ~misprediction;

   always_comb begin
      pc_d     = pc_q;
      stall_d  = stall_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (misprediction) begin
         pc_d     = correct_pc;
         stall_d  = 1'b0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            // JALR target is unknown here, so fetch parks until the redirect arrives
            if (is_jalr) begin
               stall_d = 1'b1;
            end else if (pred) begin
               pc_d = pc_q + imm_x;
            end else begin
               pc_d = pc_plus4;
            end
         end
         if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         stall_q  <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         instr_q  <= '{default: '0};
         imm_q    <= '{default: '0};
         pc_e_q   <= '{default: '0};
         pcp_q    <= '{default: '0};
         pred_q   <= '{default: 1'b0};
      end else begin
         pc_q     <= pc_d;
         stall_q  <= stall_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push) begin
            instr_q[wr_ptr_q] <= instruction_i;
            imm_q[wr_ptr_q]   <= imm_x;
            pc_e_q[wr_ptr_q]  <= pc_q;
            pcp_q[wr_ptr_q]   <= pc_plus4;
            pred_q[wr_ptr_q]  <= pred;
         end
      end
   end

   assign instruction_o       = instr_q[rd_ptr_q];
   assign imm_o               = imm_q[rd_ptr_q];
   assign pc_o                = pc_e_q[rd_ptr_q];
   assign pc_plus_o           = pcp_q[rd_ptr_q];
   assign branch_prediction_o = pred_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the fetch rules.
module tb_fetch_queue_stage;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcp;
      logic        pred;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        misprediction = 1'b0;
   logic [31:0] correct_pc = '0;
   logic [31:0] instruction_i = '0;
   logic        instruction_valid = 1'b0;
   logic        decode_ready = 1'b0;

   logic [31:0] current_pc, imm_o, pc_o, pc_plus_o, instruction_o;
   logic        out_valid, branch_prediction_o, full_o, empty_o, jalr_stall_o;
   logic [2:0]  count_o;

   logic [31:0] current_pc0, imm_o0, pc_o0, pc_plus_o0, instruction_o0;
   logic        out_valid0, branch_prediction_o0, full_o0, empty_o0, jalr_stall_o0;
   logic [2:0]  count_o0;

   int n_total = 0;
   int n_bad   = 0;

   ent_t        mq[$];
   logic [31:0] m_pc;
   logic        m_stall;

   always #5 clk = ~clk;

   fetch_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .BTFN_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush), .misprediction(misprediction),
      .correct_pc(correct_pc), .instruction_i(instruction_i),
      .instruction_valid(instruction_valid), .current_pc(current_pc),
      .decode_ready(decode_ready), .out_valid(out_valid), .instruction_o(instruction_o),
      .imm_o(imm_o), .pc_o(pc_o), .pc_plus_o(pc_plus_o),
      .branch_prediction_o(branch_prediction_o), .count_o(count_o), .full_o(full_o),
      .empty_o(empty_o), .jalr_stall_o(jalr_stall_o)
   );

   fetch_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .BTFN_EN(1'b0)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .misprediction(misprediction),
      .correct_pc(correct_pc), .instruction_i(instruction_i),
      .instruction_valid(instruction_valid), .current_pc(current_pc0),
      .decode_ready(decode_ready), .out_valid(out_valid0), .instruction_o(instruction_o0),
      .imm_o(imm_o0), .pc_o(pc_o0), .pc_plus_o(pc_plus_o0),
      .branch_prediction_o(branch_prediction_o0), .count_o(count_o0), .full_o(full_o0),
      .empty_o(empty_o0), .jalr_stall_o(jalr_stall_o0)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Immediate as a signed number built from the field weights of each format
   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      int v;
      case (w[6:0])
         7'h6f: begin
            v = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
            if (w[31]) v = v - (1 << 20);
         end
         7'h63: begin
            v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048;
            if (w[31]) v = v - 4096;
         end
         7'h67: begin
            v = int'(w[30:20]);
            if (w[31]) v = v - 2048;
         end
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] enc_addi();
      return {12'd1, 5'd0, 3'b000, 5'd1, 7'h13};
   endfunction

   function automatic logic [31:0] enc_jal(input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6f};
   endfunction

   function automatic logic [31:0] enc_beq(input logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_jalr();
      return {12'd4, 5'd1, 3'b000, 5'd0, 7'h67};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pc    = 32'h0;
      m_stall = 1'b0;
   endtask

   task automatic model_edge();
      bit   m_pop, m_full, m_push;
      ent_t e;
      logic [31:0] imm;
      logic [6:0]  opc;
      m_pop  = (mq.size() > 0) && decode_ready;
      m_full = (mq.size() == DEPTH);
      m_push = instruction_valid && (!m_full || m_pop) && !m_stall && !flush && !misprediction;
      if (misprediction) begin
         mq.delete();
         m_pc    = correct_pc;
         m_stall = 1'b0;
      end else if (flush) begin
         mq.delete();
      end else begin
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            opc    = instruction_i[6:0];
            imm    = ref_imm(instruction_i);
            e.instr = instruction_i;
            e.imm   = imm;
            e.pc    = m_pc;
            e.pcp   = m_pc + 32'd4;
            e.pred  = (opc == 7'h6f) || ((opc == 7'h63) && $signed(imm) < 0);
            mq.push_back(e);
            if (opc == 7'h67) m_stall = 1'b1;
            else if (e.pred)  m_pc = m_pc + imm;
            else              m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic compare_model();
      check("count", 64'(count_o), 64'(mq.size()));
      check("full", 64'(full_o), 64'(mq.size() == DEPTH));
      check("empty", 64'(empty_o), 64'(mq.size() == 0));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("current_pc", 64'(current_pc), 64'(m_pc));
      check("jalr_stall", 64'(jalr_stall_o), 64'(m_stall));
      if (mq.size() != 0) begin
         check("head_instr", 64'(instruction_o), 64'(mq[0].instr));
         check("head_imm", 64'(imm_o), 64'(mq[0].imm));
         check("head_pc", 64'(pc_o), 64'(mq[0].pc));
         check("head_pcp", 64'(pc_plus_o), 64'(mq[0].pcp));
         check("head_pred", 64'(branch_prediction_o), 64'(mq[0].pred));
      end
   endtask

   // Called just after a rising edge; applies inputs for the next edge
   task automatic cyc(input logic iv, input logic [31:0] ins, input logic dr,
                      input logic fl, input logic mp, input logic [31:0] cpc);
      instruction_valid = iv;
      instruction_i     = ins;
      decode_ready      = dr;
      flush             = fl;
      misprediction     = mp;
      correct_pc        = cpc;
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pc"}, 64'(current_pc), 64'h0);
      check({tag, "_count"}, 64'(count_o), 64'h0);
      check({tag, "_valid"}, 64'(out_valid), 64'h0);
      check({tag, "_empty"}, 64'(empty_o), 64'h1);
      check({tag, "_full"}, 64'(full_o), 64'h0);
      check({tag, "_stall"}, 64'(jalr_stall_o), 64'h0);
      check({tag, "_fields"}, {instruction_o, imm_o ^ pc_o ^ pc_plus_o},
            64'h0);
      check({tag, "_pred"}, 64'(branch_prediction_o), 64'h0);
   endtask

   initial begin
      logic [31:0] w;
      logic [6:0]  opcs [5];
      opcs[0] = 7'h13; opcs[1] = 7'h6f; opcs[2] = 7'h63; opcs[3] = 7'h67; opcs[4] = 7'h33;

      model_reset();
      #12;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // Four ADDIs with decode stalled fill the queue
      for (int k = 0; k < 4; k++) cyc(1'b1, enc_addi(), 1'b0, 1'b0, 1'b0, '0);
      check("fill_count", 64'(count_o), 64'd4);
      check("fill_full", 64'(full_o), 64'd1);
      check("fill_pc", 64'(current_pc), 64'h10);
      check("fill_head", 64'(pc_o), 64'h0);
      cyc(1'b1, enc_addi(), 1'b0, 1'b0, 1'b0, '0);
      check("full_hold_pc", 64'(current_pc), 64'h10);

      // Full queue streaming push and pop together
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b1, enc_addi(), 1'b1, 1'b0, 1'b0, '0);
         check("stream_count", 64'(count_o), 64'd4);
         check("stream_head", 64'(pc_o), 64'(32'(4 * k)));
      end

      // JAL +0x20 at 0x8
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h8);
      cyc(1'b1, enc_jal(21'h20), 1'b0, 1'b0, 1'b0, '0);
      check("jal_pred", 64'(branch_prediction_o), 64'd1);
      check("jal_pcp", 64'(pc_plus_o), 64'hc);
      check("jal_next_pc", 64'(current_pc), 64'h28);

      // BEQ -8 at 0x40, both prediction modes
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h40);
      cyc(1'b1, enc_beq(13'h1ff8), 1'b0, 1'b0, 1'b0, '0);
      check("beq_pred", 64'(branch_prediction_o), 64'd1);
      check("beq_pc", 64'(current_pc), 64'h38);
      check("beq_pred_nobtfn", 64'(branch_prediction_o0), 64'd0);
      check("beq_pc_nobtfn", 64'(current_pc0), 64'h44);

      // JALR stall released by redirect
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h200);
      cyc(1'b1, enc_jalr(), 1'b0, 1'b0, 1'b0, '0);
      check("jalr_stall_set", 64'(jalr_stall_o), 64'd1);
      check("jalr_pc_hold", 64'(current_pc), 64'h200);
      cyc(1'b1, enc_addi(), 1'b0, 1'b0, 1'b0, '0);
      check("jalr_no_push", 64'(count_o), 64'd1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h100);
      check("jalr_stall_clr", 64'(jalr_stall_o), 64'd0);
      check("jalr_redirect_pc", 64'(current_pc), 64'h100);
      check("jalr_empty", 64'(empty_o), 64'd1);

      // Flush together with misprediction, then flush alone
      for (int k = 0; k < 3; k++) cyc(1'b1, enc_addi(), 1'b0, 1'b0, 1'b0, '0);
      check("pre_flush_count", 64'(count_o), 64'd3);
      cyc(1'b1, enc_addi(), 1'b1, 1'b1, 1'b1, 32'h300);
      check("fl_mp_count", 64'(count_o), 64'd0);
      check("fl_mp_pc", 64'(current_pc), 64'h300);
      for (int k = 0; k < 2; k++) cyc(1'b1, enc_addi(), 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, enc_addi(), 1'b1, 1'b1, 1'b0, '0);
      check("flush_count", 64'(count_o), 64'd0);
      check("flush_pc", 64'(current_pc), 64'h308);

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         w = $urandom();
         w[6:0] = opcs[$urandom_range(0, 4)];
         cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 1) == 1,
             $urandom_range(0, 32) == 0, $urandom_range(0, 24) == 0,
             32'($urandom_range(0, 255)) << 2);
      end

      // Reset asserted mid-cycle must wipe everything immediately
      for (int k = 0; k < 3; k++) cyc(1'b1, enc_jal(21'h10), 1'b0, 1'b0, 1'b1 * (k == 0), 32'h80);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midreset");
      instruction_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      cyc(1'b1, enc_addi(), 1'b0, 1'b0, 1'b0, '0);
      check("post_reset_head_pc", 64'(pc_o), 64'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
